mem_bus_ctrl: RTL and testbench

//  Parametrised memory-access controller sitting between the CPU shared bus and main memory.

---
 rtl/mem_if_pkg.sv | 13 +
 rtl/mem_wait_timer.sv | 30 +++
 rtl/mem_bus_ctrl.sv | 111 +++++++++++
 tb/tb_mem_bus_ctrl.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_if_pkg.sv
// Shared types for the memory bus controller: FSM state encoding and RW sense constants.
package mem_if_pkg;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } state_e;

   localparam logic RW_READ  = 1'b1;
   localparam logic RW_WRITE = 1'b0;

endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles spent waiting for memory; pulses expired on the last allowed wait cycle.
module mem_wait_timer #(
   parameter int unsigned TIMEOUT = 15,
   parameter int unsigned CNT_W   = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

   logic [CNT_W-1:0] cnt;

   // Holds at all-ones so an unbounded wait (TIMEOUT = 0) never wraps.
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         cnt <= '0;
      end else if (enable && (cnt != '1)) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   always_comb begin
      expired = (TIMEOUT != 0) && enable && (cnt == LAST);
   end

endmodule

// File: rtl/mem_bus_ctrl.sv
// Handshaked memory-access controller: latches a bus request into MAR/MDR, waits for MFC with
// a bounded timeout, and returns read data plus an error flag.
module mem_bus_ctrl
   import mem_if_pkg::*;
#(
   parameter int unsigned DATA_W  = 16,
   parameter int unsigned ADDR_W  = 16,
   parameter int unsigned TIMEOUT = 15,
   parameter int unsigned CNT_W   = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_rw,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ack,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic [CNT_W-1:0]  err_count,
   output logic              mem_en,
   output logic              mem_rw,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_mfc
);

   state_e state;
   logic   tmr_clear;
   logic   tmr_enable;
   logic   expired;

   always_comb begin
      tmr_clear  = (state == IDLE);
      tmr_enable = (state == WAIT) && !mem_mfc;
      // Only combinational output; holding off while MFC lingers avoids a stale completion.
      req_ready  = (state == IDLE) && !mem_mfc && !reset;
   end

   mem_wait_timer #(
      .TIMEOUT (TIMEOUT),
      .CNT_W   (CNT_W)
   ) u_timer (
      .clk     (clk),
      .reset   (reset),
      .clear   (tmr_clear),
      .enable  (tmr_enable),
      .expired (expired)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         mem_en    <= 1'b0;
         mem_rw    <= RW_WRITE;
         mem_addr  <= '0;
         mem_wdata <= '0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
         err_count <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid && req_ready) begin
                  state     <= WAIT;
                  mem_en    <= 1'b1;
                  mem_rw    <= req_rw;
                  mem_addr  <= req_addr;
                  mem_wdata <= req_wdata;
               end
            end
            WAIT: begin
               // expired already excludes mem_mfc, so a same-cycle MFC completes cleanly.
               if (mem_mfc) begin
                  state     <= RESP;
                  mem_en    <= 1'b0;
                  rsp_valid <= 1'b1;
                  rsp_err   <= 1'b0;
                  rsp_rdata <= (mem_rw == RW_READ) ? mem_rdata : '0;
               end else if (expired) begin
                  state     <= RESP;
                  mem_en    <= 1'b0;
                  rsp_valid <= 1'b1;
                  rsp_err   <= 1'b1;
                  rsp_rdata <= '0;
                  if (err_count != '1) begin
                     err_count <= err_count + CNT_W'(1);
                  end
               end
            end
            RESP: begin
               if (rsp_ack) begin
                  state     <= IDLE;
                  rsp_valid <= 1'b0;
                  rsp_rdata <= '0;
                  rsp_err   <= 1'b0;
               end
            end
            default: begin
               state  <= IDLE;
               mem_en <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Scoreboard bench for mem_bus_ctrl: main instance (TIMEOUT 15, CNT_W 8) plus a narrow-counter
// instance (TIMEOUT 3, CNT_W 2) for error-count saturation.
module tb_mem_bus_ctrl;

   localparam int TO = 15;

   typedef struct {
      logic [15:0] rdata;
      logic        err;
   } rsp_t;

   logic clk = 1'b0;
   logic reset = 1'b1;

   logic        req_valid = 1'b0, req_rw = 1'b0, rsp_ack = 1'b0, mem_mfc = 1'b0;
   logic [15:0] req_addr = '0, req_wdata = '0, mem_rdata = '0;
   logic        req_ready, rsp_valid, rsp_err, mem_en, mem_rw;
   logic [15:0] rsp_rdata, mem_addr, mem_wdata;
   logic [7:0]  err_count;

   logic        s_req_valid = 1'b0, s_rsp_ack = 1'b0;
   logic        s_req_ready, s_rsp_valid, s_rsp_err, s_mem_en, s_mem_rw;
   logic [15:0] s_rsp_rdata, s_mem_addr, s_mem_wdata;
   logic [1:0]  s_err_count;

   int   n_checks = 0;
   int   n_fail   = 0;
   int   exp_errs = 0;
   rsp_t sb[$];

   always #5 clk = ~clk;

   mem_bus_ctrl #(.DATA_W(16), .ADDR_W(16), .TIMEOUT(TO), .CNT_W(8)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ack(rsp_ack), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .err_count(err_count),
      .mem_en(mem_en), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_mfc(mem_mfc)
   );

   mem_bus_ctrl #(.DATA_W(16), .ADDR_W(16), .TIMEOUT(3), .CNT_W(2)) u_sat (
      .clk(clk), .reset(reset),
      .req_valid(s_req_valid), .req_ready(s_req_ready), .req_rw(1'b1),
      .req_addr(16'h0080), .req_wdata(16'h0000),
      .rsp_valid(s_rsp_valid), .rsp_ack(s_rsp_ack), .rsp_rdata(s_rsp_rdata),
      .rsp_err(s_rsp_err), .err_count(s_err_count),
      .mem_en(s_mem_en), .mem_rw(s_mem_rw), .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata),
      .mem_rdata(16'hFFFF), .mem_mfc(1'b0)
   );

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   // One full transaction; mfc_at = 0 means memory never answers.
   task automatic do_txn(input logic rw, input logic [15:0] addr, input logic [15:0] wdata,
                         input logic [15:0] rdata, input int mfc_at, input int ack_delay,
                         input string name);
      rsp_t exp;
      int   exp_en;
      int   en_cycles;
      exp.err   = (mfc_at == 0) || (mfc_at > TO);
      exp_en    = exp.err ? TO : mfc_at;
      exp.rdata = (exp.err || !rw) ? 16'h0000 : rdata;
      if (exp.err && exp_errs < 255) exp_errs++;
      sb.push_back(exp);

      n_checks++;
      if (req_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL %s req_ready: got %b expected 1", name, req_ready);
      end
      req_valid = 1'b1; req_rw = rw; req_addr = addr; req_wdata = wdata;
      step;
      req_valid = 1'b0;
      req_addr  = ~addr;
      req_wdata = ~wdata;

      en_cycles = 0;
      while (mem_en === 1'b1 && en_cycles < 100) begin
         en_cycles++;
         n_checks++;
         if (mem_addr !== addr || mem_rw !== rw || (!rw && mem_wdata !== wdata)) begin
            n_fail++;
            $display("FAIL %s mem bus cycle %0d: got addr %h rw %b wdata %h expected %h %b %h",
                     name, en_cycles, mem_addr, mem_rw, mem_wdata, addr, rw, wdata);
         end
         mem_rdata = 16'hDEAD;
         if (en_cycles == mfc_at) begin
            mem_mfc   = 1'b1;
            mem_rdata = rdata;
         end
         step;
         mem_mfc   = 1'b0;
         mem_rdata = 16'h0000;
      end

      n_checks++;
      if (en_cycles != exp_en) begin
         n_fail++;
         $display("FAIL %s mem_en cycles: got %0d expected %0d", name, en_cycles, exp_en);
      end
      n_checks++;
      if (rsp_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL %s rsp_valid latency: got %b expected 1", name, rsp_valid);
      end
      exp = sb.pop_front();
      for (int i = 0; i <= ack_delay; i++) begin
         if (i > 0) step;
         n_checks++;
         if (rsp_valid !== 1'b1 || rsp_rdata !== exp.rdata || rsp_err !== exp.err) begin
            n_fail++;
            $display("FAIL %s rsp hold %0d: got v%b d%h e%b expected v1 d%h e%b", name, i,
                     rsp_valid, rsp_rdata, rsp_err, exp.rdata, exp.err);
         end
      end
      rsp_ack = 1'b1;
      step;
      rsp_ack = 1'b0;
      n_checks++;
      if (rsp_valid !== 1'b0 || mem_en !== 1'b0) begin
         n_fail++;
         $display("FAIL %s after ack: got rsp_valid %b mem_en %b expected 0 0",
                  name, rsp_valid, mem_en);
      end
      n_checks++;
      if (err_count !== 8'(exp_errs)) begin
         n_fail++;
         $display("FAIL %s err_count: got %0d expected %0d", name, err_count, exp_errs);
      end
   endtask

   task automatic test_reset;
      reset = 1'b1;
      step;
      step;
      n_checks++;
      if (mem_en !== 1'b0 || rsp_valid !== 1'b0 || err_count !== 8'd0 || req_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_state: got en %b v %b cnt %0d rdy %b expected 0 0 0 0",
                  mem_en, rsp_valid, err_count, req_ready);
      end
      reset = 1'b0;
      exp_errs = 0;
      step;
      n_checks++;
      if (req_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_ready: got %b expected 1", req_ready);
      end
   endtask

   task automatic test_reset_mid;
      req_valid = 1'b1; req_rw = 1'b1; req_addr = 16'h0200;
      step;
      req_valid = 1'b0;
      step;
      n_checks++;
      if (mem_en !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_mid_wait: got mem_en %b expected 1", mem_en);
      end
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step;
         n_checks++;
         if (mem_en !== 1'b0 || rsp_valid !== 1'b0 || err_count !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_mid %0d: got en %b v %b cnt %0d expected 0 0 0",
                     i, mem_en, rsp_valid, err_count);
         end
      end
      reset = 1'b0;
      exp_errs = 0;
      step;
      step;
      n_checks++;
      if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || mem_en !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mid_after: got rdy %b v %b en %b expected 1 0 0",
                  req_ready, rsp_valid, mem_en);
      end
   endtask

   task automatic test_read;
      do_txn(1'b1, 16'h0040, 16'h5555, 16'hBEEF, 3, 0, "read_mfc3");
   endtask

   task automatic test_write;
      do_txn(1'b0, 16'h0010, 16'h1234, 16'hAAAA, 1, 0, "write_mfc1");
   endtask

   task automatic test_timeout;
      do_txn(1'b1, 16'h0300, 16'h0000, 16'hC0DE, 0, 0, "timeout");
      do_txn(1'b1, 16'h0304, 16'h0000, 16'h7E57, TO, 0, "mfc_at_limit");
   endtask

   task automatic test_resp_hold;
      do_txn(1'b1, 16'h0444, 16'h0000, 16'h9876, 2, 5, "resp_hold");
   endtask

   task automatic test_stuck_mfc;
      do_txn(1'b0, 16'h0500, 16'hFACE, 16'h0000, 1, 0, "stuck_pre");
      mem_mfc = 1'b1;
      req_valid = 1'b1; req_rw = 1'b1; req_addr = 16'h0504;
      #1;
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if (req_ready !== 1'b0 || mem_en !== 1'b0) begin
            n_fail++;
            $display("FAIL stuck_mfc %0d: got rdy %b en %b expected 0 0", i, req_ready, mem_en);
         end
         step;
      end
      req_valid = 1'b0;
      mem_mfc = 1'b0;
      #1;
      n_checks++;
      if (req_ready !== 1'b1 || mem_en !== 1'b0) begin
         n_fail++;
         $display("FAIL stuck_mfc_release: got rdy %b en %b expected 1 0", req_ready, mem_en);
      end
      step;
   endtask

   task automatic test_back_to_back;
      do_txn(1'b1, 16'h0600, 16'h0000, 16'h1111, 1, 0, "b2b_0");
      do_txn(1'b0, 16'h0602, 16'h2222, 16'h0000, 2, 0, "b2b_1");
      do_txn(1'b1, 16'h0604, 16'h0000, 16'h3333, 4, 1, "b2b_2");
   endtask

   task automatic test_saturation;
      int guard;
      int exp_cnt;
      for (int i = 0; i < 5; i++) begin
         exp_cnt = (i + 1 > 3) ? 3 : i + 1;
         s_req_valid = 1'b1;
         step;
         s_req_valid = 1'b0;
         guard = 0;
         while (s_rsp_valid !== 1'b1 && guard < 50) begin
            step;
            guard++;
         end
         n_checks++;
         if (s_rsp_valid !== 1'b1 || s_rsp_err !== 1'b1 || s_err_count !== 2'(exp_cnt)) begin
            n_fail++;
            $display("FAIL saturation %0d: got v %b e %b cnt %0d expected 1 1 %0d",
                     i, s_rsp_valid, s_rsp_err, s_err_count, exp_cnt);
         end
         s_rsp_ack = 1'b1;
         step;
         s_rsp_ack = 1'b0;
      end
   endtask

   initial begin
      test_reset;
      test_read;
      test_write;
      test_timeout;
      test_reset_mid;
      test_resp_hold;
      test_stuck_mfc;
      test_back_to_back;
      test_saturation;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
